// File: rtl/i2c_slave_pkg.sv
// Shared types and sizes for the I2C target register endpoint.
package i2c_slave_pkg;

    localparam int NREGS  = 8;
    localparam int PTR_W  = 3;
    localparam int BYTE_W = 8;

    typedef enum logic [3:0] {
        IDLE,
        RX_ADDR,
        ACK_ADDR,
        RX_PTR,
        ACK_PTR,
        RX_DATA,
        ACK_DATA,
        TX_DATA,
        RX_MACK,
        WAIT_STOP
    } state_t;

endpackage

// File: rtl/i2c_slave_regs_if.sv
// Pad-level I2C lines plus the local host register port of i2c_slave_regs.
interface i2c_slave_regs_if;
    import i2c_slave_pkg::*;

    logic              scl_pad_i;
    logic              sda_pad_i;
    logic              sda_pad_o;
    logic              sda_padoen_o;
    logic [PTR_W-1:0]  reg_adr_i;
    logic [BYTE_W-1:0] reg_dat_i;
    logic              reg_we_i;
    logic [BYTE_W-1:0] reg_dat_o;
    logic              busy_o;
    logic              stop_o;

    modport slave (
        input  scl_pad_i, sda_pad_i, reg_adr_i, reg_dat_i, reg_we_i,
        output sda_pad_o, sda_padoen_o, reg_dat_o, busy_o, stop_o
    );

    modport master (
        output scl_pad_i, sda_pad_i, reg_adr_i, reg_dat_i, reg_we_i,
        input  sda_pad_o, sda_padoen_o, reg_dat_o, busy_o, stop_o
    );

endinterface

// File: rtl/i2c_slave_sync.sv
// Pad synchronizers and bus-event detection; every event output is a registered one-cycle pulse.
module i2c_slave_sync (
    input  logic wb_clk_i,
    input  logic arst_i,
    input  logic scl_pad,
    input  logic sda_pad,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_lvl
);

    logic scl_s1, scl_s2, scl_h;
    logic sda_s1, sda_s2, sda_h;

    // Flops reset to the idle-high bus level so leaving reset never fakes an edge.
    always_ff @(posedge wb_clk_i or posedge arst_i) begin
        if (arst_i) begin
            scl_s1    <= 1'b1;
            scl_s2    <= 1'b1;
            scl_h     <= 1'b1;
            sda_s1    <= 1'b1;
            sda_s2    <= 1'b1;
            sda_h     <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_s1    <= scl_pad;
            scl_s2    <= scl_s1;
            scl_h     <= scl_s2;
            sda_s1    <= sda_pad;
            sda_s2    <= sda_s1;
            sda_h     <= sda_s2;
            scl_rise  <= scl_s2 & ~scl_h;
            scl_fall  <= ~scl_s2 & scl_h;
            start_det <= scl_s2 & scl_h & sda_h & ~sda_s2;
            stop_det  <= scl_s2 & scl_h & ~sda_h & sda_s2;
        end
    end

    // sda_h holds the sample the event pulses were derived from.
    assign sda_lvl = sda_h;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target with an 8-byte register bank, auto-incrementing pointer and a parallel host port.
//
// state     | meaning
// IDLE      | bus free or not addressed, waiting for START
// RX_ADDR   | shifting in address + R/W
// ACK_ADDR  | driving ACK for our address
// RX_PTR    | shifting in register pointer byte
// ACK_PTR   | driving ACK for pointer byte
// RX_DATA   | shifting in a write data byte
// ACK_DATA  | driving ACK for a data byte
// TX_DATA   | shifting reg[ptr] out
// RX_MACK   | sampling master ACK/NACK after a read byte
// WAIT_STOP | ignoring the bus until START or STOP
module i2c_slave_regs
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0] SLV_ADDR = 7'h3C
) (
    input logic             wb_clk_i,
    input logic             arst_i,
    i2c_slave_regs_if.slave bus
);

    state_t            state_q, state_d;
    logic              scl_rise, scl_fall, start_p, stop_p, sda_lvl;
    logic [2:0]        cnt_q;
    logic [BYTE_W-1:0] sh_q, byte_in;
    logic [BYTE_W-1:0] regs [NREGS];
    logic [PTR_W-1:0]  ptr_q;
    logic              drive_q, drive_d, busy_q;
    logic              byte_done, addr_hit;
    logic              shift_rx, shift_tx, i2c_we, ptr_load, ptr_inc, load_tx, busy_set;

    i2c_slave_sync u_sync (
        .wb_clk_i  (wb_clk_i),
        .arst_i    (arst_i),
        .scl_pad   (bus.scl_pad_i),
        .sda_pad   (bus.sda_pad_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_p),
        .stop_det  (stop_p),
        .sda_lvl   (sda_lvl)
    );

    assign byte_in   = {sh_q[BYTE_W-2:0], sda_lvl};
    assign addr_hit  = (byte_in[7:1] == SLV_ADDR);
    assign byte_done = scl_rise && (cnt_q == 3'd7);

    always_ff @(posedge wb_clk_i or posedge arst_i) begin
        if (arst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start_p) begin
            state_d = RX_ADDR;
        end else if (stop_p) begin
            state_d = IDLE;
        end else if (scl_rise) begin
            case (state_q)
                RX_ADDR:  if (byte_done) state_d = addr_hit ? ACK_ADDR : WAIT_STOP;
                ACK_ADDR: state_d = sh_q[0] ? TX_DATA : RX_PTR;
                RX_PTR:   if (byte_done) state_d = ACK_PTR;
                ACK_PTR:  state_d = RX_DATA;
                RX_DATA:  if (byte_done) state_d = ACK_DATA;
                ACK_DATA: state_d = RX_DATA;
                TX_DATA:  if (byte_done) state_d = RX_MACK;
                RX_MACK:  state_d = sda_lvl ? WAIT_STOP : TX_DATA;
                default:  state_d = state_q;
            endcase
        end
    end

    // drive_d is the SDA pull-down wanted for the coming SCL-low phase.
    always_comb begin
        shift_rx = 1'b0;
        shift_tx = 1'b0;
        i2c_we   = 1'b0;
        ptr_load = 1'b0;
        ptr_inc  = 1'b0;
        load_tx  = 1'b0;
        busy_set = 1'b0;
        drive_d  = 1'b0;
        case (state_q)
            RX_ADDR: begin
                shift_rx = scl_rise;
                busy_set = byte_done && addr_hit;
            end
            ACK_ADDR: begin
                drive_d = 1'b1;
                load_tx = scl_rise && sh_q[0];
            end
            RX_PTR: begin
                shift_rx = scl_rise;
                ptr_load = byte_done;
            end
            ACK_PTR, ACK_DATA: drive_d = 1'b1;
            RX_DATA: begin
                shift_rx = scl_rise;
                i2c_we   = byte_done;
                ptr_inc  = byte_done;
            end
            TX_DATA: begin
                shift_tx = scl_rise;
                ptr_inc  = byte_done;
                drive_d  = ~sh_q[7];
            end
            RX_MACK: load_tx = scl_rise && !sda_lvl;
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q   <= '0;
            sh_q    <= '0;
            ptr_q   <= '0;
            drive_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            if (start_p || stop_p)       cnt_q <= '0;
            else if (shift_rx || shift_tx) cnt_q <= cnt_q + 3'd1;

            if (load_tx)       sh_q <= regs[ptr_q];
            else if (shift_rx) sh_q <= byte_in;
            else if (shift_tx) sh_q <= {sh_q[BYTE_W-2:0], 1'b0};

            if (ptr_load)     ptr_q <= byte_in[PTR_W-1:0];
            else if (ptr_inc) ptr_q <= ptr_q + PTR_W'(1);

            // SDA only moves after a detected SCL fall, except the release on START/STOP.
            if (start_p || stop_p) drive_q <= 1'b0;
            else if (scl_fall)     drive_q <= drive_d;

            if (stop_p)        busy_q <= 1'b0;
            else if (busy_set) busy_q <= 1'b1;
        end
    end

    // Host write wins a same-cycle collision; the I2C byte is simply dropped.
    always_ff @(posedge wb_clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            bus.reg_dat_o <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (bus.reg_we_i && (bus.reg_adr_i == PTR_W'(i)))
                    regs[i] <= bus.reg_dat_i;
                else if (i2c_we && (ptr_q == PTR_W'(i)))
                    regs[i] <= byte_in;
            end
            bus.reg_dat_o <= regs[bus.reg_adr_i];
        end
    end

    assign bus.sda_pad_o    = 1'b0;
    assign bus.sda_padoen_o = ~drive_q;
    assign bus.busy_o       = busy_q;
    assign bus.stop_o       = stop_p;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Scoreboard bench for i2c_slave_regs: bit-banged I2C master plus host-port accesses.
module tb_i2c_slave_regs;

    localparam int Q = 50;
    localparam logic [7:0] AW  = {7'h3C, 1'b0};
    localparam logic [7:0] AR  = {7'h3C, 1'b1};
    localparam logic [7:0] BAD = {7'h3B, 1'b0};

    logic clk, rst, scl, sda_m;
    int   n_cmp = 0;
    int   n_err = 0;
    int   stop_cnt = 0;
    logic [7:0] exp_q [$];

    i2c_slave_regs_if bus();
    assign bus.scl_pad_i = scl;
    assign bus.sda_pad_i = sda_m & (bus.sda_padoen_o | bus.sda_pad_o);

    i2c_slave_regs #(.SLV_ADDR(7'h3C)) dut (
        .wb_clk_i (clk),
        .arst_i   (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (bus.stop_o === 1'b1) stop_cnt <= stop_cnt + 1;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h want %02h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic [7:0] v);
        exp_q.push_back(v);
    endtask

    task automatic sb_pop(input string tag, input logic [7:0] obs);
        logic [7:0] e;
        e = 8'hxx;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk(tag, obs, e);
    endtask

    task automatic clk_bit(input logic b, output logic r);
        #(Q) sda_m = b;
        #(Q) scl = 1'b1;
        #(Q) r = bus.sda_pad_i;
        #(Q) scl = 1'b0;
    endtask

    task automatic i2c_start();
        sda_m = 1'b0;
        #(2*Q) scl = 1'b0;
    endtask

    task automatic i2c_rstart();
        #(Q) sda_m = 1'b1;
        #(Q) scl = 1'b1;
        #(Q) sda_m = 1'b0;
        #(Q) scl = 1'b0;
    endtask

    task automatic i2c_stop();
        #(Q) sda_m = 1'b0;
        #(Q) scl = 1'b1;
        #(Q) sda_m = 1'b1;
        #(2*Q);
    endtask

    // exp_sda is the line level wanted on the 9th clock: 0 = ACK, 1 = NACK.
    task automatic send_byte(input logic [7:0] b, input logic exp_sda, input logic collide);
        logic r;
        sb_push({7'b0, exp_sda});
        for (int i = 7; i >= 0; i--) begin
            if (collide && i == 0) begin
                #(Q) sda_m = b[0];
                #(Q) scl = 1'b1;
                fork
                    begin
                        repeat (3) @(posedge clk);
                        #5;
                        bus.reg_adr_i = 3'd4;
                        bus.reg_dat_i = 8'h99;
                        bus.reg_we_i  = 1'b1;
                        #10 bus.reg_we_i = 1'b0;
                    end
                join_none
                #(2*Q) scl = 1'b0;
            end else begin
                clk_bit(b[i], r);
            end
        end
        clk_bit(1'b1, r);
        sb_pop("ack", {7'b0, r});
    endtask

    task automatic recv_byte(input string tag, input logic [7:0] exp, input logic mack);
        logic [7:0] d;
        logic r;
        sb_push(exp);
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, r);
            d[i] = r;
        end
        clk_bit(mack, r);
        sb_pop(tag, d);
    endtask

    task automatic host_wr(input logic [2:0] adr, input logic [7:0] dat);
        @(negedge clk);
        bus.reg_adr_i = adr;
        bus.reg_dat_i = dat;
        bus.reg_we_i  = 1'b1;
        @(negedge clk);
        bus.reg_we_i  = 1'b0;
    endtask

    task automatic host_rd(input logic [2:0] adr, input logic [7:0] exp, input string tag);
        sb_push(exp);
        @(negedge clk);
        bus.reg_adr_i = adr;
        @(negedge clk);
        sb_pop(tag, bus.reg_dat_o);
    endtask

    task automatic stop_and_check();
        int c0;
        c0 = stop_cnt;
        i2c_stop();
        repeat (4) @(negedge clk);
        chk("stop_pulse", 8'(stop_cnt - c0), 8'd1);
        chk("busy_off", {7'b0, bus.busy_o}, 8'h00);
    endtask

    initial begin
        logic r;
        logic [3:0] nib;

        rst = 1'b1;
        scl = 1'b1;
        sda_m = 1'b1;
        bus.reg_we_i  = 1'b0;
        bus.reg_adr_i = 3'd0;
        bus.reg_dat_i = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_oe",   {7'b0, bus.sda_padoen_o}, 8'h01);
        chk("rst_sdao", {7'b0, bus.sda_pad_o},    8'h00);
        chk("rst_busy", {7'b0, bus.busy_o},       8'h00);
        chk("rst_stop", {7'b0, bus.stop_o},       8'h00);
        chk("rst_dat",  bus.reg_dat_o,            8'h00);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // plain write burst through the pointer
        i2c_start();
        send_byte(AW, 1'b0, 1'b0);
        chk("busy_on", {7'b0, bus.busy_o}, 8'h01);
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'hA5, 1'b0, 1'b0);
        send_byte(8'h5A, 1'b0, 1'b0);
        stop_and_check();
        host_rd(3'd2, 8'hA5, "wr_reg2");
        host_rd(3'd3, 8'h5A, "wr_reg3");

        // STOP after 4 data bits: no write, ptr stays 2
        i2c_start();
        send_byte(AW, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) clk_bit(1'b1, r);
        stop_and_check();
        host_rd(3'd2, 8'hA5, "part_reg2");
        i2c_start();
        send_byte(AR, 1'b0, 1'b0);
        recv_byte("part_ptr", 8'hA5, 1'b1);
        i2c_stop();

        // read burst with pointer wrap
        host_wr(3'd6, 8'h11);
        host_wr(3'd7, 8'h22);
        host_wr(3'd0, 8'h33);
        i2c_start();
        send_byte(AW, 1'b0, 1'b0);
        send_byte(8'h06, 1'b0, 1'b0);
        i2c_rstart();
        send_byte(AR, 1'b0, 1'b0);
        recv_byte("rd_reg6", 8'h11, 1'b0);
        recv_byte("rd_reg7", 8'h22, 1'b0);
        recv_byte("rd_reg0", 8'h33, 1'b1);
        repeat (10) @(negedge clk);
        chk("nack_rel", {7'b0, bus.sda_padoen_o}, 8'h01);
        stop_and_check();

        // foreign address is ignored
        i2c_start();
        send_byte(BAD, 1'b1, 1'b0);
        chk("bad_busy", {7'b0, bus.busy_o}, 8'h00);
        send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'h77, 1'b1, 1'b0);
        i2c_stop();
        host_rd(3'd0, 8'h33, "bad_reg0");
        host_rd(3'd7, 8'h22, "bad_reg7");

        // host-written value read back over I2C
        host_wr(3'd1, 8'hC3);
        i2c_start();
        send_byte(AW, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        i2c_rstart();
        send_byte(AR, 1'b0, 1'b0);
        recv_byte("host_rd1", 8'hC3, 1'b1);
        i2c_stop();

        // same-cycle host and I2C write to reg4
        i2c_start();
        send_byte(AW, 1'b0, 1'b0);
        send_byte(8'h04, 1'b0, 1'b0);
        send_byte(8'h44, 1'b0, 1'b1);
        send_byte(8'h55, 1'b0, 1'b0);
        i2c_stop();
        host_rd(3'd4, 8'h99, "coll_reg4");
        host_rd(3'd5, 8'h55, "coll_reg5");

        // reset during the 5th bit of a read of reg0 (33: bit 3 is 0, so SDA is pulled)
        i2c_start();
        send_byte(AW, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        i2c_rstart();
        send_byte(AR, 1'b0, 1'b0);
        sb_push(8'h03);
        for (int i = 3; i >= 0; i--) begin
            clk_bit(1'b1, r);
            nib[i] = r;
        end
        sb_pop("rd_nibble", {4'h0, nib});
        #(Q) sda_m = 1'b1;
        #(Q) scl = 1'b1;
        #(Q);
        chk("drv_bit4", {7'b0, bus.sda_padoen_o}, 8'h00);
        rst = 1'b1;
        #1;
        chk("arst_oe", {7'b0, bus.sda_padoen_o}, 8'h01);
        chk("arst_busy", {7'b0, bus.busy_o}, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        scl = 1'b0;
        i2c_stop();
        for (int i = 0; i < 8; i++) host_rd(3'(i), 8'h00, "arst_reg");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
